fm_sweep_ctrl: RTL and testbench

- Parametrised frequency-sweep controller. It produces a phase-increment (tuning) word `dout` for the downstream NCO/phase accumulator.
- Successor to the fixed 256-entry linear-increment table. The increment is computed as start + k*step by accumulation, so no table is stored.
- Start, step, number of points and dwell length are programmable.
- Three sweep modes: sawtooth, triangle, single-shot. A run/stop control and update/wrap strobes drive downstream retiming.

---
 rtl/fm_sweep_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_fm_sweep_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fm_sweep_ctrl.sv
// Frequency-sweep controller: sawtooth/triangle/single-shot NCO increment word.
// Define FMC_DITHER_EN to add LFSR dither LSBs onto dout.
module fm_sweep_ctrl #(
  parameter int DSIZE     = 20,
  parameter int IDXW      = 8,
  parameter int DIVW      = 12,
  parameter int DITH_BITS = 4
) (
  input  logic             inc,
  input  logic             rst,
  input  logic             run,
  input  logic [DSIZE-1:0] cfg_start,
  input  logic [DSIZE-1:0] cfg_step,
  input  logic [IDXW-1:0]  cfg_npts,
  input  logic [DIVW-1:0]  cfg_div,
  input  logic [1:0]       cfg_mode,
  output logic [DSIZE-1:0] dout,
  output logic             update,
  output logic             wrap,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DN   = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t           state;
  state_t           st_n;
  logic [DSIZE-1:0] acc;
  logic [DSIZE-1:0] acc_n;
  logic [IDXW-1:0]  idx;
  logic [IDXW-1:0]  idx_n;
  logic [DIVW-1:0]  div;
  logic [DIVW-1:0]  div_n;
  logic             upd_n;
  logic             wrp_n;
  logic             load;

  logic [DSIZE-1:0] s_start;
  logic [DSIZE-1:0] s_step;
  logic [IDXW-1:0]  s_npts;
  logic [DIVW-1:0]  s_div;
  logic [1:0]       s_mode;

  logic [DITH_BITS-1:0] dith;

  logic last;
  logic is_tri;
  logic is_shot;
  logic dn_step;
  logic up_inc;
  logic up_hold;
  logic up_turn;
  logic up_rld;

  assign last    = (idx == s_npts);
  assign is_tri  = (s_mode == 2'd1);
  assign is_shot = (s_mode == 2'd2);

  // exactly one of these is set whenever a step action fires
  assign dn_step = (state == DN);
  assign up_inc  = (state == UP) && !last;
  assign up_hold = (state == UP) && last && is_shot;
  assign up_turn = (state == UP) && last && is_tri &&
                   (s_npts != '0);
  assign up_rld  = (state == UP) && last && !is_shot &&
                   !(is_tri && (s_npts != '0));

  always_comb begin
    st_n  = state;
    acc_n = acc;
    idx_n = idx;
    div_n = div;
    upd_n = 1'b0;
    wrp_n = 1'b0;
    load  = 1'b0;
    unique case (state)
      IDLE: begin
        if (run) begin
          load  = 1'b1;
          st_n  = UP;
          acc_n = cfg_start;
          idx_n = '0;
          div_n = '0;
          upd_n = 1'b1;
          wrp_n = 1'b1;
        end
      end
      UP, DN: begin
        if (!run) begin
          st_n = IDLE;
        end else if (div != s_div) begin
          div_n = div + DIVW'(1);
        end else begin
          div_n = '0;
          unique case (1'b1)
            dn_step: begin
              idx_n = idx - IDXW'(1);
              acc_n = acc - s_step;
              upd_n = 1'b1;
              if (idx == IDXW'(1)) begin
                st_n  = UP;
                wrp_n = 1'b1;
              end
            end
            up_inc: begin
              idx_n = idx + IDXW'(1);
              acc_n = acc + s_step;
              upd_n = 1'b1;
            end
            up_hold: begin
              st_n = HOLD;
            end
            up_turn: begin
              st_n  = DN;
              idx_n = idx - IDXW'(1);
              acc_n = acc - s_step;
              upd_n = 1'b1;
            end
            up_rld: begin
              idx_n = '0;
              acc_n = s_start;
              upd_n = 1'b1;
              wrp_n = 1'b1;
            end
          endcase
        end
      end
      HOLD: begin
        if (!run) st_n = IDLE;
      end
    endcase
  end

`ifdef FMC_DITHER_EN
  logic [15:0] lfsr;
  logic [15:0] lfsr_n;

  assign lfsr_n = {lfsr[14:0],
                   lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign dith   = lfsr_n[DITH_BITS-1:0];

  always_ff @(posedge inc or posedge rst) begin
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= lfsr_n;
  end
`else
  assign dith = '0;
`endif

  always_ff @(posedge inc or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      idx     <= '0;
      div     <= '0;
      dout    <= '0;
      update  <= 1'b0;
      wrap    <= 1'b0;
      busy    <= 1'b0;
      s_start <= '0;
      s_step  <= '0;
      s_npts  <= '0;
      s_div   <= '0;
      s_mode  <= '0;
    end else begin
      state  <= st_n;
      acc    <= acc_n;
      idx    <= idx_n;
      div    <= div_n;
      update <= upd_n;
      wrap   <= wrp_n;
      busy   <= (st_n == UP) || (st_n == DN);
      dout   <= acc_n + DSIZE'(dith);
      if (load) begin
        s_start <= cfg_start;
        s_step  <= cfg_step;
        s_npts  <= cfg_npts;
        s_div   <= cfg_div;
        s_mode  <= cfg_mode;
      end
    end
  end

endmodule

// File: tb/tb_fm_sweep_ctrl.sv
// Scoreboard bench for fm_sweep_ctrl (dither macro undefined).
module tb_fm_sweep_ctrl;

  logic        inc = 1'b0;
  logic        rst;
  logic        run;
  logic [19:0] cfg_start;
  logic [19:0] cfg_step;
  logic [7:0]  cfg_npts;
  logic [11:0] cfg_div;
  logic [1:0]  cfg_mode;
  logic [19:0] dout;
  logic        update;
  logic        wrap;
  logic        busy;

  typedef struct packed {
    logic [19:0] d;
    logic        u;
    logic        w;
    logic        b;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  fm_sweep_ctrl dut (
    .inc       (inc),
    .rst       (rst),
    .run       (run),
    .cfg_start (cfg_start),
    .cfg_step  (cfg_step),
    .cfg_npts  (cfg_npts),
    .cfg_div   (cfg_div),
    .cfg_mode  (cfg_mode),
    .dout      (dout),
    .update    (update),
    .wrap      (wrap),
    .busy      (busy)
  );

  always #5 inc = ~inc;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic exp_t mk(logic [19:0] d, logic u,
                              logic w, logic b);
    exp_t e;
    e.d = d;
    e.u = u;
    e.w = w;
    e.b = b;
    return e;
  endfunction

  // closed-form expectation at cycle t after the start edge
  function automatic exp_t model(int mode, logic [19:0] s,
                                 logic [19:0] st, int n,
                                 int d, int t);
    exp_t   e;
    int     p;
    int     k;
    longint v;
    p = t / d;
    if (mode == 1 && n > 0) begin
      p = p % (2 * n);
      k = (p <= n) ? p : 2 * n - p;
    end else begin
      p = p % (n + 1);
      k = p;
    end
    v = longint'(s) + longint'(k) * longint'(st);
    e.d = v[19:0];
    e.u = (t % d) == 0;
    e.w = e.u && (p == 0);
    e.b = 1'b1;
    return e;
  endfunction

  task automatic cyc(string tag, exp_t e);
    exp_t g;
    sb.push_back(e);
    @(posedge inc);
    #1;
    g = sb.pop_front();
    chk({tag, "_dout"}, 32'(dout), 32'(g.d));
    chk({tag, "_update"}, 32'(update), 32'(g.u));
    chk({tag, "_wrap"}, 32'(wrap), 32'(g.w));
    chk({tag, "_busy"}, 32'(busy), 32'(g.b));
  endtask

  task automatic sweep(string tag, int mode, logic [19:0] s,
                       logic [19:0] st, int n, int d,
                       int t0, int t1);
    for (int t = t0; t <= t1; t++)
      cyc(tag, model(mode, s, st, n, d, t));
  endtask

  initial begin
    exp_t e;
    rst       = 1'b1;
    run       = 1'b0;
    cfg_start = 20'd2796;
    cfg_step  = 20'd535;
    cfg_npts  = 8'd3;
    cfg_div   = 12'd2;
    cfg_mode  = 2'd0;
    repeat (2) @(posedge inc);
    #1;
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_update", 32'(update), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    cyc("idle", mk(20'd0, 1'b0, 1'b0, 1'b0));

    // sawtooth, step change mid-sweep must be ignored
    run = 1'b1;
    sweep("saw", 0, 20'd2796, 20'd535, 3, 3, 0, 5);
    cfg_step = 20'd1000;
    sweep("saw", 0, 20'd2796, 20'd535, 3, 3, 6, 25);
    run = 1'b0;
    e = model(0, 20'd2796, 20'd535, 3, 3, 25);
    cyc("saw_stop", mk(e.d, 1'b0, 1'b0, 1'b0));
    cyc("saw_idle", mk(e.d, 1'b0, 1'b0, 1'b0));

    // triangle, stop coinciding with a dwell end
    cfg_step = 20'd535;
    cfg_mode = 2'd1;
    run      = 1'b1;
    sweep("tri", 1, 20'd2796, 20'd535, 3, 3, 0, 35);
    run = 1'b0;
    e = model(1, 20'd2796, 20'd535, 3, 3, 35);
    cyc("tri_stop", mk(e.d, 1'b0, 1'b0, 1'b0));

    // single-shot with hold and restart
    cfg_mode = 2'd2;
    cfg_div  = 12'd0;
    run      = 1'b1;
    cyc("ss0", mk(20'd2796, 1'b1, 1'b1, 1'b1));
    cyc("ss1", mk(20'd3331, 1'b1, 1'b0, 1'b1));
    cyc("ss2", mk(20'd3866, 1'b1, 1'b0, 1'b1));
    cyc("ss3", mk(20'd4401, 1'b1, 1'b0, 1'b1));
    for (int i = 0; i < 3; i++)
      cyc("ss_hold", mk(20'd4401, 1'b0, 1'b0, 1'b0));
    run = 1'b0;
    cyc("ss_idle", mk(20'd4401, 1'b0, 1'b0, 1'b0));
    run = 1'b1;
    cyc("ss_rst0", mk(20'd2796, 1'b1, 1'b1, 1'b1));
    cyc("ss_rst1", mk(20'd3331, 1'b1, 1'b0, 1'b1));
    run = 1'b0;
    cyc("ss_stop", mk(20'd3331, 1'b0, 1'b0, 1'b0));

    // modulo 2^20 wrap of the accumulator
    cfg_start = 20'd1048476;
    cfg_step  = 20'd200;
    cfg_npts  = 8'd1;
    cfg_div   = 12'd0;
    cfg_mode  = 2'd0;
    run       = 1'b1;
    cyc("mod0", mk(20'd1048476, 1'b1, 1'b1, 1'b1));
    cyc("mod1", mk(20'd100, 1'b1, 1'b0, 1'b1));
    sweep("mod", 0, 20'd1048476, 20'd200, 1, 1, 2, 5);
    run = 1'b0;
    cyc("mod_stop", mk(20'd100, 1'b0, 1'b0, 1'b0));

    // asynchronous reset between edges
    cfg_start = 20'd2796;
    cfg_step  = 20'd535;
    cfg_npts  = 8'd3;
    cfg_div   = 12'd2;
    run       = 1'b1;
    sweep("pre_rst", 0, 20'd2796, 20'd535, 3, 3, 0, 12);
    #2 rst = 1'b1;
    #1;
    chk("arst_dout", 32'(dout), 32'd0);
    chk("arst_update", 32'(update), 32'd0);
    chk("arst_wrap", 32'(wrap), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge inc);
    #1 rst = 1'b0;
    sweep("post_rst", 0, 20'd2796, 20'd535, 3, 3, 0, 6);
    run = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
